// File: rtl/tl_sram_slave.sv
// TileLink-UL SRAM responder: one request in flight, programmable wait states,
// denies out-of-range, misaligned and unsupported requests.
module tl_sram_slave #(
    parameter logic [63:0] ADDR_BASE = 64'h0000_0000_8000_0000,
    parameter int unsigned DEPTH     = 4096,
    parameter int unsigned LATENCY   = 1,
    parameter int unsigned SRC_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [2:0]       a_opcode,
    input  logic [2:0]       a_size,
    input  logic [SRC_W-1:0] a_source,
    input  logic [63:0]      a_address,
    input  logic [7:0]       a_mask,
    input  logic [63:0]      a_data,
    output logic             d_valid,
    input  logic             d_ready,
    output logic [2:0]       d_opcode,
    output logic [2:0]       d_size,
    output logic [SRC_W-1:0] d_source,
    output logic             d_denied,
    output logic [63:0]      d_data
);

    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam logic [63:0] SPAN     = 64'(DEPTH) << 3;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [2:0]       op_q;
    logic [2:0]       size_q;
    logic [SRC_W-1:0] src_q;
    logic [63:0]      addr_q;
    logic [7:0]       mask_q;
    logic [63:0]      wdata_q;

    logic [2:0]       d_op_q;
    logic [2:0]       d_size_q;
    logic [SRC_W-1:0] d_src_q;
    logic             d_den_q;
    logic [63:0]      d_data_q;

    logic [63:0] mem [DEPTH];

    logic             accept;
    logic             commit;
    logic [63:0]      off;
    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic             misal;
    logic             op_ok;
    logic             is_get;
    logic             denied;
    logic             wr_en;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (a_valid) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (d_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // output logic
    always_comb begin
        a_ready = (state_q == S_IDLE);
        d_valid = (state_q == S_RESP);
        accept  = (state_q == S_IDLE) && a_valid;
        commit  = (state_q == S_WAIT) && (cnt_q == 4'd0);
    end

    // Unsigned offset wraps for addresses below base, so one compare covers both ends.
    always_comb begin
        off      = addr_q - ADDR_BASE;
        idx      = off[IDX_W+2:3];
        in_range = (off < SPAN);
        op_ok    = (op_q == 3'd0) || (op_q == 3'd1) || (op_q == 3'd4);
        is_get   = (op_q == 3'd4);
        misal    = 1'b1;
        case (size_q)
            3'd0:    misal = 1'b0;
            3'd1:    misal = addr_q[0];
            3'd2:    misal = |addr_q[1:0];
            3'd3:    misal = |addr_q[2:0];
            default: misal = 1'b1;
        endcase
        denied = !in_range || misal || !op_ok;
        wr_en  = commit && !denied && !is_get;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= 3'd0;
            size_q  <= 3'd0;
            src_q   <= '0;
            addr_q  <= 64'd0;
            mask_q  <= 8'd0;
            wdata_q <= 64'd0;
        end else if (accept) begin
            op_q    <= a_opcode;
            size_q  <= a_size;
            src_q   <= a_source;
            addr_q  <= a_address;
            mask_q  <= a_mask;
            wdata_q <= a_data;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (mask_q[i]) begin
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_op_q   <= 3'd0;
            d_size_q <= 3'd0;
            d_src_q  <= '0;
            d_den_q  <= 1'b0;
            d_data_q <= 64'd0;
        end else if (commit) begin
            d_op_q   <= is_get ? 3'd1 : 3'd0;
            d_size_q <= size_q;
            d_src_q  <= src_q;
            d_den_q  <= denied;
            d_data_q <= (is_get && !denied) ? mem[idx] : 64'd0;
        end
    end

    assign d_opcode = d_op_q;
    assign d_size   = d_size_q;
    assign d_source = d_src_q;
    assign d_denied = d_den_q;
    assign d_data   = d_data_q;

endmodule

// File: tb/tb_tl_sram_slave.sv
// Bench for tl_sram_slave: directed vector table, reset and wait-state
// sequences, and random traffic against a word-array reference model.
module tb_tl_sram_slave;

    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
    localparam logic [63:0] SPAN = 64'd32768;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [2:0]  a_opcode = 3'd0;
    logic [2:0]  a_size = 3'd0;
    logic [3:0]  a_source = 4'd0;
    logic [63:0] a_address = 64'd0;
    logic [7:0]  a_mask = 8'd0;
    logic [63:0] a_data = 64'd0;
    logic        d_valid;
    logic        d_ready = 1'b0;
    logic [2:0]  d_opcode;
    logic [2:0]  d_size;
    logic [3:0]  d_source;
    logic        d_denied;
    logic [63:0] d_data;

    logic        b_a_valid = 1'b0;
    logic        b_a_ready;
    logic [2:0]  b_a_opcode = 3'd0;
    logic [2:0]  b_a_size = 3'd0;
    logic [3:0]  b_a_source = 4'd0;
    logic [63:0] b_a_address = 64'd0;
    logic [7:0]  b_a_mask = 8'd0;
    logic [63:0] b_a_data = 64'd0;
    logic        b_d_valid;
    logic        b_d_ready = 1'b0;
    logic [2:0]  b_d_opcode;
    logic [2:0]  b_d_size;
    logic [3:0]  b_d_source;
    logic        b_d_denied;
    logic [63:0] b_d_data;

    tl_sram_slave #(.LATENCY(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready),
        .a_opcode(a_opcode), .a_size(a_size),
        .a_source(a_source), .a_address(a_address),
        .a_mask(a_mask), .a_data(a_data),
        .d_valid(d_valid), .d_ready(d_ready),
        .d_opcode(d_opcode), .d_size(d_size),
        .d_source(d_source), .d_denied(d_denied),
        .d_data(d_data)
    );

    tl_sram_slave #(.LATENCY(4)) u4 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(b_a_valid), .a_ready(b_a_ready),
        .a_opcode(b_a_opcode), .a_size(b_a_size),
        .a_source(b_a_source), .a_address(b_a_address),
        .a_mask(b_a_mask), .a_data(b_a_data),
        .d_valid(b_d_valid), .d_ready(b_d_ready),
        .d_opcode(b_d_opcode), .d_size(b_d_size),
        .d_source(b_d_source), .d_denied(b_d_denied),
        .d_data(b_d_data)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  sz;
        logic [3:0]  src;
        logic [63:0] addr;
        logic [7:0]  mask;
        logic [63:0] data;
        logic [2:0]  e_op;
        logic        e_den;
        logic [63:0] e_data;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic [2:0] op, input logic [2:0] sz, input logic [3:0] src,
        input logic [63:0] addr, input logic [7:0] mask,
        input logic [63:0] data, input logic [2:0] e_op,
        input logic e_den, input logic [63:0] e_data);
        vec_t v;
        v.op = op; v.sz = sz; v.src = src; v.addr = addr;
        v.mask = mask; v.data = data; v.e_op = e_op;
        v.e_den = e_den; v.e_data = e_data;
        return v;
    endfunction

    // One full transaction on u1; stall = D-edges with d_ready low.
    task automatic txn(
        input logic [2:0] op, input logic [2:0] sz, input logic [3:0] src,
        input logic [63:0] addr, input logic [7:0] mask,
        input logic [63:0] data, input int stall,
        output logic [2:0] r_op, output logic r_den,
        output logic [63:0] r_data, output logic [2:0] r_sz,
        output logic [3:0] r_src, output int lat);
        @(negedge clk);
        a_valid = 1'b1; a_opcode = op; a_size = sz; a_source = src;
        a_address = addr; a_mask = mask; a_data = data;
        d_ready = (stall == 0);
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) a_valid = 1'b0;
        end while (!d_valid && lat < 40);
        r_op = d_opcode; r_den = d_denied; r_data = d_data;
        r_sz = d_size; r_src = d_source;
        if (!d_valid) begin
            chk("d_valid_timeout", 64'(d_valid), 64'd1);
            d_ready = 1'b0;
            return;
        end
        if (stall > 0) d_ready = 1'b0;
        for (int s = 1; s <= stall; s++) begin
            @(negedge clk);
            chk("stall_dvalid", 64'(d_valid), 64'd1);
            chk("stall_ardy", 64'(a_ready), 64'd0);
            chk("stall_data", d_data, r_data);
            if (s == stall) d_ready = 1'b1;
        end
        @(negedge clk);
        chk("post_hs_dvalid", 64'(d_valid), 64'd0);
        chk("post_hs_ardy", 64'(a_ready), 64'd1);
        d_ready = 1'b0;
    endtask

    // Reference model: memory as an associative array of 64-bit words.
    logic [63:0] mdl [longint unsigned];

    task automatic model(
        input logic [2:0] op, input logic [2:0] sz, input logic [63:0] addr,
        input logic [7:0] mask, input logic [63:0] data,
        output logic [2:0] e_op, output logic e_den, output logic [63:0] e_data);
        logic ok_rng, ok_aln, ok_op;
        longint unsigned w;
        logic [63:0] cur;
        ok_rng = (addr >= BASE) && (addr < BASE + SPAN);
        ok_aln = (sz <= 3'd3) && ((addr % (64'd1 << sz)) == 64'd0);
        ok_op  = (op == 3'd0) || (op == 3'd1) || (op == 3'd4);
        e_den  = !(ok_rng && ok_aln && ok_op);
        e_op   = (op == 3'd4) ? 3'd1 : 3'd0;
        e_data = 64'd0;
        if (!e_den) begin
            w = longint'((addr - BASE) / 64'd8);
            if (op == 3'd4) begin
                e_data = mdl[w];
            end else begin
                cur = mdl.exists(w) ? mdl[w] : 64'd0;
                for (int i = 0; i < 8; i++)
                    if (mask[i]) cur[8*i +: 8] = data[8*i +: 8];
                mdl[w] = cur;
            end
        end
    endtask

    // LATENCY=4 instance transaction: d_valid expected at the 5th sample.
    task automatic l4_run(
        input logic [2:0] op, input logic [3:0] src, input logic [63:0] addr,
        input logic [63:0] data, input logic [2:0] e_op,
        input logic [63:0] e_data, input int stall);
        @(negedge clk);
        b_a_valid = 1'b1; b_a_opcode = op; b_a_size = 3'd3;
        b_a_source = src; b_a_address = addr; b_a_mask = 8'hFF;
        b_a_data = data; b_d_ready = (stall == 0);
        @(posedge clk);
        for (int k = 1; k <= 5 + stall; k++) begin
            @(negedge clk);
            if (k == 1) b_a_valid = 1'b0;
            chk("l4_ardy", 64'(b_a_ready), 64'd0);
            if (k < 5) begin
                chk("l4_wait_dvalid", 64'(b_d_valid), 64'd0);
            end else begin
                chk("l4_resp_dvalid", 64'(b_d_valid), 64'd1);
                chk("l4_opcode", 64'(b_d_opcode), 64'(e_op));
                chk("l4_source", 64'(b_d_source), 64'(src));
                chk("l4_denied", 64'(b_d_denied), 64'd0);
                chk("l4_data", b_d_data, e_data);
            end
            if (stall > 0 && k == 5 + stall) b_d_ready = 1'b1;
        end
        @(negedge clk);
        chk("l4_post_dvalid", 64'(b_d_valid), 64'd0);
        chk("l4_post_ardy", 64'(b_a_ready), 64'd1);
        b_d_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  r_op, r_sz, e_op, op, sz;
        logic        r_den, e_den;
        logic [63:0] r_data, e_data, addr, data;
        logic [3:0]  r_src, src;
        logic [7:0]  mask;
        logic [63:0] oor [4];
        int          lat;

        tbl.push_back(mk(3'd0, 3'd3, 4'h1, 64'h8000_0000, 8'hFF, 64'h0123_4567_89AB_CDEF, 3'd0, 1'b0, 64'd0));
        tbl.push_back(mk(3'd0, 3'd3, 4'h3, 64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, 3'd0, 1'b0, 64'd0));
        tbl.push_back(mk(3'd4, 3'd3, 4'h5, 64'h8000_0010, 8'h00, 64'd0, 3'd1, 1'b0, 64'h1122_3344_5566_7788));
        tbl.push_back(mk(3'd1, 3'd1, 4'h2, 64'h8000_0012, 8'h0C, 64'h0000_0000_AABB_0000, 3'd0, 1'b0, 64'd0));
        tbl.push_back(mk(3'd4, 3'd3, 4'h6, 64'h8000_0010, 8'h00, 64'd0, 3'd1, 1'b0, 64'h1122_3344_AABB_7788));
        tbl.push_back(mk(3'd4, 3'd3, 4'h7, 64'h7FFF_FFF8, 8'h00, 64'd0, 3'd1, 1'b1, 64'd0));
        tbl.push_back(mk(3'd4, 3'd3, 4'h8, 64'h8000_8000, 8'h00, 64'd0, 3'd1, 1'b1, 64'd0));
        tbl.push_back(mk(3'd0, 3'd2, 4'h9, 64'h8000_0002, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 1'b1, 64'd0));
        tbl.push_back(mk(3'd4, 3'd3, 4'hA, 64'h8000_0000, 8'h00, 64'd0, 3'd1, 1'b0, 64'h0123_4567_89AB_CDEF));
        tbl.push_back(mk(3'd2, 3'd3, 4'hB, 64'h8000_0000, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 3'd0, 1'b1, 64'd0));
        tbl.push_back(mk(3'd4, 3'd5, 4'hC, 64'h8000_0000, 8'h00, 64'd0, 3'd1, 1'b1, 64'd0));
        tbl.push_back(mk(3'd4, 3'd0, 4'hD, 64'h8000_0013, 8'h00, 64'd0, 3'd1, 1'b0, 64'h1122_3344_AABB_7788));
        tbl.push_back(mk(3'd0, 3'd3, 4'hE, 64'h8000_7FF8, 8'hFF, 64'hCAFE_F00D_1234_5678, 3'd0, 1'b0, 64'd0));
        tbl.push_back(mk(3'd4, 3'd3, 4'hF, 64'h8000_7FF8, 8'h00, 64'd0, 3'd1, 1'b0, 64'hCAFE_F00D_1234_5678));
        tbl.push_back(mk(3'd1, 3'd0, 4'h4, 64'h8000_0001, 8'h02, 64'h0000_0000_0000_EE00, 3'd0, 1'b0, 64'd0));
        tbl.push_back(mk(3'd4, 3'd3, 4'h1, 64'h8000_0000, 8'h00, 64'd0, 3'd1, 1'b0, 64'h0123_4567_89AB_EEEF));

        repeat (3) @(negedge clk);
        chk("rst_ardy", 64'(a_ready), 64'd1);
        chk("rst_dvalid", 64'(d_valid), 64'd0);
        chk("rst_dopcode", 64'(d_opcode), 64'd0);
        chk("rst_ddata", d_data, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ardy", 64'(a_ready), 64'd1);
        chk("idle_dvalid", 64'(d_valid), 64'd0);

        foreach (tbl[i]) begin
            txn(tbl[i].op, tbl[i].sz, tbl[i].src, tbl[i].addr, tbl[i].mask,
                tbl[i].data, i % 3, r_op, r_den, r_data, r_sz, r_src, lat);
            chk($sformatf("v%0d_opcode", i), 64'(r_op), 64'(tbl[i].e_op));
            chk($sformatf("v%0d_denied", i), 64'(r_den), 64'(tbl[i].e_den));
            chk($sformatf("v%0d_data", i), r_data, tbl[i].e_data);
            chk($sformatf("v%0d_source", i), 64'(r_src), 64'(tbl[i].src));
            chk($sformatf("v%0d_size", i), 64'(r_sz), 64'(tbl[i].sz));
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'd2);
        end

        // Reset during the WAIT cycle of a Put: the write must be lost.
        txn(3'd0, 3'd3, 4'h2, 64'h8000_0020, 8'hFF, 64'hAAAA_5555_AAAA_5555,
            0, r_op, r_den, r_data, r_sz, r_src, lat);
        @(negedge clk);
        a_valid = 1'b1; a_opcode = 3'd0; a_size = 3'd3; a_source = 4'h3;
        a_address = 64'h8000_0020; a_mask = 8'hFF;
        a_data = 64'h1234_5678_9ABC_DEF0; d_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        chk("rstw_ardy_wait", 64'(a_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("rstw_dvalid", 64'(d_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        d_ready = 1'b0;
        @(negedge clk);
        chk("rstw_ardy_rel", 64'(a_ready), 64'd1);
        chk("rstw_dvalid_rel", 64'(d_valid), 64'd0);
        txn(3'd4, 3'd3, 4'h4, 64'h8000_0020, 8'h00, 64'd0,
            0, r_op, r_den, r_data, r_sz, r_src, lat);
        chk("rstw_old_data", r_data, 64'hAAAA_5555_AAAA_5555);

        l4_run(3'd0, 4'h7, 64'h8000_0040, 64'h0F1E_2D3C_4B5A_6978,
               3'd0, 64'd0, 3);
        l4_run(3'd4, 4'h9, 64'h8000_0040, 64'd0,
               3'd1, 64'h0F1E_2D3C_4B5A_6978, 0);

        oor[0] = BASE - 64'd8;
        oor[1] = BASE + SPAN;
        oor[2] = BASE + SPAN + 64'h100;
        oor[3] = 64'd0;
        for (int w = 0; w < 8; w++) begin
            addr = BASE + 64'h100 + 64'(w) * 64'd8;
            data = {$urandom, $urandom};
            model(3'd0, 3'd3, addr, 8'hFF, data, e_op, e_den, e_data);
            txn(3'd0, 3'd3, 4'(w), addr, 8'hFF, data, 0,
                r_op, r_den, r_data, r_sz, r_src, lat);
            chk("fill_denied", 64'(r_den), 64'(e_den));
        end

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 7))
                0, 1:    op = 3'd0;
                2, 3:    op = 3'd1;
                7:       op = 3'($urandom_range(0, 7));
                default: op = 3'd4;
            endcase
            if ($urandom_range(0, 9) == 0) sz = 3'($urandom_range(4, 7));
            else sz = 3'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) begin
                addr = oor[$urandom_range(0, 3)];
            end else begin
                addr = BASE + 64'h100 + 64'($urandom_range(0, 7)) * 64'd8;
                if ($urandom_range(0, 3) != 0 && sz <= 3'd3)
                    addr = addr + (64'($urandom_range(0, 7)) & ~((64'd1 << sz) - 64'd1));
                else
                    addr = addr + 64'($urandom_range(0, 7));
            end
            mask = 8'($urandom);
            data = {$urandom, $urandom};
            src  = 4'($urandom);
            model(op, sz, addr, mask, data, e_op, e_den, e_data);
            txn(op, sz, src, addr, mask, data, int'($urandom_range(0, 2)),
                r_op, r_den, r_data, r_sz, r_src, lat);
            chk($sformatf("r%0d_opcode", n), 64'(r_op), 64'(e_op));
            chk($sformatf("r%0d_denied", n), 64'(r_den), 64'(e_den));
            chk($sformatf("r%0d_data", n), r_data, e_data);
            chk($sformatf("r%0d_source", n), 64'(r_src), 64'(src));
            chk($sformatf("r%0d_size", n), 64'(r_sz), 64'(sz));
            chk($sformatf("r%0d_latency", n), 64'(lat), 64'd2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
